fdiv_driver: RTL

Initiator for the half-precision divider's stb/ack operand/result protocol. Accepts an operand pair from a host valid/ready stream and presents `a`, then `b`, to the divider under stb/ack. Collects `z` and returns it to the host. Includes a per-phase timeout that recovers a hung divider with a reset pulse and reports a NaN result.

---
 rtl/fdiv_driver.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/fdiv_driver.sv
// fdiv_driver: feeds operand pairs from a host valid/ready stream to a
// half-precision divider over its a/b/z stb-ack channels, returns the
// quotient to the host, and recovers a hung divider with a per-phase timeout.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | ready for a host operand pair
// S_SEND_A | presenting dividend on input_a with input_a_stb
// S_SEND_B | presenting divisor on input_b with input_b_stb
// S_WAIT_Z | acknowledging the divider's quotient on output_z
// S_RESULT | holding res_z/res_timeout valid until the host takes them
module fdiv_driver #(
  parameter int               WIDTH     = 16,
  parameter int               TIMEOUT   = 255,
  parameter logic [WIDTH-1:0] NAN_VALUE = WIDTH'(16'h7e00)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_valid,
  output logic             op_ready,
  output logic [WIDTH-1:0] res_z,
  output logic             res_timeout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             div_rst,
  output logic [WIDTH-1:0] input_a,
  output logic             input_a_stb,
  input  logic             input_a_ack,
  output logic [WIDTH-1:0] input_b,
  output logic             input_b_stb,
  input  logic             input_b_ack,
  input  logic [WIDTH-1:0] output_z,
  input  logic             output_z_stb,
  output logic             output_z_ack,
  output logic [15:0]      done_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_A,
    S_SEND_B,
    S_WAIT_Z,
    S_RESULT
  } state_t;

  // Last phase-counter value before a phase without a transfer is abandoned.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_z_q, res_z_d;
  logic             res_timeout_q, res_timeout_d;
  logic [15:0]      done_count_q, done_count_d;
  logic             op_ready_q, op_ready_d;
  logic             res_valid_q, res_valid_d;
  logic             div_rst_q, div_rst_d;
  logic             a_stb_q, a_stb_d;
  logic             b_stb_q, b_stb_d;
  logic             z_ack_q, z_ack_d;
  logic             abort;

  // Next-state, phase timer and next values of every registered output.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    a_d           = a_q;
    b_d           = b_q;
    res_z_d       = res_z_q;
    res_timeout_d = res_timeout_q;
    done_count_d  = done_count_q;
    div_rst_d     = 1'b0;
    abort         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (op_valid && op_ready_q) begin
          a_d     = op_a;
          b_d     = op_b;
          cnt_d   = '0;
          state_d = S_SEND_A;
        end
      end
      S_SEND_A: begin
        if (a_stb_q && input_a_ack) begin
          cnt_d   = '0;
          state_d = S_SEND_B;
        end else if (cnt_q == CNT_LAST) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_SEND_B: begin
        if (b_stb_q && input_b_ack) begin
          cnt_d   = '0;
          state_d = S_WAIT_Z;
        end else if (cnt_q == CNT_LAST) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_WAIT_Z: begin
        if (z_ack_q && output_z_stb) begin
          res_z_d       = output_z;
          res_timeout_d = 1'b0;
          state_d       = S_RESULT;
        end else if (cnt_q == CNT_LAST) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_RESULT: begin
        if (res_ready) begin
          done_count_d = done_count_q + 16'd1;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A transfer in the final counted cycle takes the branches above, so
    // abort only fires when the phase really ran out.
    if (abort) begin
      state_d       = S_RESULT;
      res_z_d       = NAN_VALUE;
      res_timeout_d = 1'b1;
      div_rst_d     = 1'b1;
    end

    // Handshake outputs follow the state being entered, so they are
    // registered and line up with the state they belong to.
    op_ready_d  = (state_d == S_IDLE);
    a_stb_d     = (state_d == S_SEND_A);
    b_stb_d     = (state_d == S_SEND_B);
    z_ack_d     = (state_d == S_WAIT_Z);
    res_valid_d = (state_d == S_RESULT);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      a_q           <= '0;
      b_q           <= '0;
      res_z_q       <= '0;
      res_timeout_q <= 1'b0;
      done_count_q  <= '0;
      op_ready_q    <= 1'b1;
      res_valid_q   <= 1'b0;
      div_rst_q     <= 1'b0;
      a_stb_q       <= 1'b0;
      b_stb_q       <= 1'b0;
      z_ack_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      a_q           <= a_d;
      b_q           <= b_d;
      res_z_q       <= res_z_d;
      res_timeout_q <= res_timeout_d;
      done_count_q  <= done_count_d;
      op_ready_q    <= op_ready_d;
      res_valid_q   <= res_valid_d;
      div_rst_q     <= div_rst_d;
      a_stb_q       <= a_stb_d;
      b_stb_q       <= b_stb_d;
      z_ack_q       <= z_ack_d;
    end
  end

  assign op_ready     = op_ready_q;
  assign res_z        = res_z_q;
  assign res_timeout  = res_timeout_q;
  assign res_valid    = res_valid_q;
  assign div_rst      = div_rst_q;
  assign input_a      = a_q;
  assign input_a_stb  = a_stb_q;
  assign input_b      = b_q;
  assign input_b_stb  = b_stb_q;
  assign output_z_ack = z_ack_q;
  assign done_count   = done_count_q;

endmodule
